// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter between fetch and MEM stage.
// Holds the FSM state and owner encodings, the default widths/limits, and a
// helper that sizes the small counters.
package imem_dmem_arbiter_pkg;

  localparam int AW_DEFAULT           = 32;
  localparam int DW_DEFAULT           = 32;
  localparam int STARVE_LIMIT_DEFAULT = 3;
  localparam int TIMEOUT_DEFAULT      = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Bits needed to represent 0..max_val, never fewer than one.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_timeout_counter.sv
// arb_timeout_counter: counts BUSY cycles spent waiting for mem_ack.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the count (asserted on every grant)
//   inc        : advance the count (BUSY cycle without ack)
//   expired    : count has reached LIMIT-1; always 0 when LIMIT==0
module arb_timeout_counter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int            CW   = cnt_width(LIMIT);
  localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : {CW{1'b0}};

  logic [CW-1:0] count_r;

  // Elapsed-cycle register: zeroed on grant, advances while the ack is outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (inc) begin
      count_r <= count_r + CW'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  // The abort fires on the LIMIT-th busy cycle, i.e. while the count shows LIMIT-1.
  assign expired = (LIMIT != 0) && (count_r == LAST);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-ported memory between instruction fetch
// and the MEM stage, one transaction at a time. Data wins ties unless fetch has
// already lost STARVE_LIMIT consecutive ties; hung transactions are aborted
// after TIMEOUT busy cycles (0 disables the abort).
// Ports:
//   clk, reset                       : clock, asynchronous active-high reset
//   if_req/if_addr -> if_rdata/if_done : fetch read channel
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_done : load/store channel
//   err_timeout                      : pulses with the done of an aborted access
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata : memory side
//   stall_if, stall_d                : request pending and not completing this cycle
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int AW           = AW_DEFAULT,
  parameter int DW           = DW_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int TIMEOUT      = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          err_timeout,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_d
);

  localparam int             WCW      = cnt_width(STARVE_LIMIT);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(STARVE_LIMIT);

  state_e         state_r;
  state_e         state_s;
  owner_e         owner_r;
  logic           mem_req_r;
  logic           mem_we_r;
  logic [AW-1:0]  mem_addr_r;
  logic [DW-1:0]  mem_wdata_r;
  logic [WCW-1:0] wait_cnt_r;

  logic grant_i_s;
  logic grant_d_s;
  logic busy_s;
  logic expired_s;
  logic finish_s;
  logic abort_s;

  assign busy_s   = (state_r != IDLE);
  // An ack arriving on the timeout cycle wins, so abort requires no ack.
  assign finish_s = busy_s & (mem_ack | expired_s);
  assign abort_s  = busy_s & ~mem_ack & expired_s;

  arb_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_to_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant_i_s | grant_d_s),
    .inc     (busy_s & ~mem_ack),
    .expired (expired_s)
  );

  // Next-state and grant decode; arbitration only happens from IDLE.
  always_comb begin
    state_s   = state_r;
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (d_req && (!if_req || (wait_cnt_r != WAIT_MAX))) begin
          grant_d_s = 1'b1;
          state_s   = BUSY_D;
        end else if (if_req) begin
          grant_i_s = 1'b1;
          state_s   = BUSY_I;
        end else begin
          state_s   = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (finish_s) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state, owner and the registered memory-side request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      owner_r     <= OWN_I;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
    end else begin
      state_r <= state_s;
      if (grant_d_s) begin
        owner_r     <= OWN_D;
        mem_req_r   <= 1'b1;
        mem_we_r    <= d_we;
        mem_addr_r  <= d_addr;
        mem_wdata_r <= d_wdata;
      end else if (grant_i_s) begin
        owner_r     <= OWN_I;
        mem_req_r   <= 1'b1;
        mem_we_r    <= 1'b0;
        mem_addr_r  <= if_addr;
        mem_wdata_r <= {DW{1'b0}};
      end else if (finish_s) begin
        mem_req_r   <= 1'b0;
      end else begin
        mem_req_r   <= mem_req_r;
      end
    end
  end

  // Starvation counter: consecutive ties fetch has lost, cleared when fetch wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= {WCW{1'b0}};
    end else if (grant_i_s) begin
      wait_cnt_r <= {WCW{1'b0}};
    end else if (grant_d_s && if_req && (wait_cnt_r != WAIT_MAX)) begin
      wait_cnt_r <= wait_cnt_r + WCW'(1'b1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Completion routing: done to the owner, read data only on a real ack.
  always_comb begin
    if_done  = 1'b0;
    d_done   = 1'b0;
    if_rdata = {DW{1'b0}};
    d_rdata  = {DW{1'b0}};
    if (finish_s) begin
      if (owner_r == OWN_I) begin
        if_done  = 1'b1;
        if_rdata = mem_ack ? mem_rdata : {DW{1'b0}};
      end else begin
        d_done   = 1'b1;
        d_rdata  = (mem_ack && !mem_we_r) ? mem_rdata : {DW{1'b0}};
      end
    end else begin
      if_done  = 1'b0;
      d_done   = 1'b0;
    end
  end

  assign err_timeout = abort_s;
  assign mem_req     = mem_req_r;
  assign mem_we      = mem_we_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;

  // Reset masks the stalls so they drop at once, without waiting for a clock.
  assign stall_if = if_req & ~if_done & ~reset;
  assign stall_d  = d_req & ~d_done & ~reset;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
module tb_imem_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int ST = 3;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req, d_req, d_we, mem_ack;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_done, d_done, err_timeout, mem_req, mem_we, stall_if, stall_d;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(ST), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .err_timeout(err_timeout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_d(stall_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    if_req = 1'b1; d_req = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_mem: req=%0b we=%0b addr=%h wdata=%h, required all 0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    n_checks++;
    if ({if_done, d_done, err_timeout, stall_if, stall_d} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: if_done=%0b d_done=%0b err=%0b stall_if=%0b stall_d=%0b, required 0", if_done, d_done, err_timeout, stall_if, stall_d);
    end
    n_checks++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: if_rdata=%h d_rdata=%h, required 0", if_rdata, d_rdata);
    end
    clear_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_fetch_only();
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_0010;
    @(negedge clk);
    n_checks++;
    if ({mem_req, stall_if} !== 2'b01) begin
      n_fail++;
      $display("FAIL fetch_req_cycle: mem_req=%0b stall_if=%0b, required 0/1", mem_req, stall_if);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, mem_addr, if_done, stall_if} !== {1'b1, 1'b0, 32'h10, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL fetch_grant: req=%0b we=%0b addr=%h done=%0b stall=%0b, required 1/0/10/0/1", mem_req, mem_we, mem_addr, if_done, stall_if);
    end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    @(negedge clk);
    n_checks++;
    if ({if_done, if_rdata, stall_if, d_done} !== {1'b1, 32'h0050_0093, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_done: done=%0b rdata=%h stall=%0b d_done=%0b, required 1/00500093/0/0", if_done, if_rdata, stall_if, d_done);
    end
    tick();
    if_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_req, if_done, if_rdata} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL fetch_after: mem_req=%0b done=%0b rdata=%h, required 0/0/0", mem_req, if_done, if_rdata);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
    tick();
    @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_d} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL simul_data_first: req=%0b we=%0b addr=%h wdata=%h stall_if=%0b stall_d=%0b, required 1/1/100/deadbeef/1/1", mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_d);
    end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if ({d_done, d_rdata, stall_d, stall_if, if_done} !== {1'b1, 32'h0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL simul_store_done: d_done=%0b d_rdata=%h stall_d=%0b stall_if=%0b if_done=%0b, required 1/0/0/1/0", d_done, d_rdata, stall_d, stall_if, if_done);
    end
    tick();
    d_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_req, stall_if} !== 2'b01) begin
      n_fail++;
      $display("FAIL simul_gap: mem_req=%0b stall_if=%0b, required 0/1", mem_req, stall_if);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, mem_addr, stall_if} !== {1'b1, 1'b0, 32'h40, 1'b1}) begin
      n_fail++;
      $display("FAIL simul_fetch_next: req=%0b we=%0b addr=%h stall_if=%0b, required 1/0/40/1", mem_req, mem_we, mem_addr, stall_if);
    end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    n_checks++;
    if ({if_done, if_rdata} !== {1'b1, 32'h13}) begin
      n_fail++;
      $display("FAIL simul_fetch_done: done=%0b rdata=%h, required 1/13", if_done, if_rdata);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_starvation();
    int  losses, got, exp_wait;
    logic exp_fetch, bump;
    do_reset();
    losses = 0; got = 0;
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'h1;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      mem_ack = mem_req;
      mem_rdata = $urandom;
      @(negedge clk);
      bump = if_done | d_done;
      if (bump) begin
        exp_fetch = (losses == ST);
        exp_wait  = exp_fetch ? 0 : ((losses < ST) ? losses + 1 : ST);
        n_checks++;
        if ({if_done, d_done} !== {exp_fetch, ~exp_fetch}) begin
          n_fail++;
          $display("FAIL starve_order: grant %0d if_done=%0b d_done=%0b, required fetch=%0b", got, if_done, d_done, exp_fetch);
        end
        n_checks++;
        if (dut.wait_cnt_r !== 2'(exp_wait)) begin
          n_fail++;
          $display("FAIL starve_wait_cnt: grant %0d wait_cnt=%0d, required %0d", got, dut.wait_cnt_r, exp_wait);
        end
        n_checks++;
        if ((exp_fetch ? stall_d : stall_if) !== 1'b1) begin
          n_fail++;
          $display("FAIL starve_stall: grant %0d loser stall=%0b, required 1", got, exp_fetch ? stall_d : stall_if);
        end
        losses = exp_wait;
        got++;
      end
      tick();
      if (bump) begin
        d_addr = d_addr + 32'h4;
        if_addr = if_addr + 32'h4;
      end
    end
    n_checks++;
    if (got != 8) begin
      n_fail++;
      $display("FAIL starve_budget: %0d transactions completed, required 8", got);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout();
    for (int ack_last = 0; ack_last < 2; ack_last++) begin
      do_reset();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; mem_rdata = 32'hA5A5_5A5A;
      tick();
      for (int c = 1; c <= TO; c++) begin
        mem_ack = (ack_last == 1) && (c == TO);
        @(negedge clk);
        n_checks++;
        if (c < TO) begin
          if ({d_done, err_timeout, mem_req} !== 3'b001) begin
            n_fail++;
            $display("FAIL timeout_wait: ack_last=%0d cycle %0d d_done=%0b err=%0b mem_req=%0b, required 0/0/1", ack_last, c, d_done, err_timeout, mem_req);
          end
        end else begin
          if ({d_done, err_timeout, d_rdata} !== {1'b1, (ack_last == 0), (ack_last == 1) ? 32'hA5A5_5A5A : 32'h0}) begin
            n_fail++;
            $display("FAIL timeout_end: ack_last=%0d d_done=%0b err=%0b d_rdata=%h, required 1/%0b/%h", ack_last, d_done, err_timeout, d_rdata, (ack_last == 0), (ack_last == 1) ? 32'hA5A5_5A5A : 32'h0);
          end
        end
        tick();
      end
      d_req = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({mem_req, d_done, err_timeout} !== 3'b000) begin
        n_fail++;
        $display("FAIL timeout_after: ack_last=%0d mem_req=%0b d_done=%0b err=%0b, required 0", ack_last, mem_req, d_done, err_timeout);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    if_req = 1'b1; if_addr = 32'h3000;
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h55;
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h77;
    #1;
    n_checks++;
    if ({mem_req, if_done, stall_if, stall_d} !== 4'b1101) begin
      n_fail++;
      $display("FAIL midreset_before: req=%0b done=%0b stall_if=%0b stall_d=%0b, required 1/1/0/1", mem_req, if_done, stall_if, stall_d);
    end
    mem_ack = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_req, if_done, stall_if, stall_d, mem_addr} !== {4'b0000, 32'h0}) begin
      n_fail++;
      $display("FAIL midreset_async: req=%0b done=%0b stall_if=%0b stall_d=%0b addr=%h, required all 0", mem_req, if_done, stall_if, stall_d, mem_addr);
    end
    clear_inputs();
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dut.wait_cnt_r, dut.u_to_cnt.count_r, mem_req} !== 6'b0) begin
      n_fail++;
      $display("FAIL midreset_counters: wait=%0d to=%0d req=%0b, required 0", dut.wait_cnt_r, dut.u_to_cnt.count_r, mem_req);
    end
  endtask

  task automatic test_stray_ack();
    do_reset();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    n_checks++;
    if ({if_done, d_done, err_timeout, mem_req, if_rdata, d_rdata} !== {4'b0000, 64'h0}) begin
      n_fail++;
      $display("FAIL stray_ack: if_done=%0b d_done=%0b err=%0b req=%0b if_rdata=%h d_rdata=%h, required 0", if_done, d_done, err_timeout, mem_req, if_rdata, d_rdata);
    end
    tick();
    mem_ack = 1'b0; if_req = 1'b1; if_addr = 32'h8;
    tick();
    @(negedge clk);
    n_checks++;
    if ({mem_req, mem_addr, if_done} !== {1'b1, 32'h8, 1'b0}) begin
      n_fail++;
      $display("FAIL stray_then_grant: req=%0b addr=%h done=%0b, required 1/8/0", mem_req, mem_addr, if_done);
    end
    do_reset();
  endtask

  // Randomized traffic checked against a transaction-level model:
  // owner 0=none 1=fetch 2=data, el = busy cycles already elapsed,
  // losses = ties fetch has lost in a row.
  task automatic test_random();
    int owner, el, losses;
    logic [31:0] t_addr, t_wdata, e_if_rdata, e_d_rdata;
    logic t_we, f_pend, d_pend, f_fin, d_fin, e_fin, e_abort, e_if_done, e_d_done;
    do_reset();
    owner = 0; el = 0; losses = 0; f_pend = 1'b0; d_pend = 1'b0; f_fin = 1'b0; d_fin = 1'b0;
    t_addr = 32'h0; t_wdata = 32'h0; t_we = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (f_fin) f_pend = 1'b0;
      if (d_fin) d_pend = 1'b0;
      if (!f_pend && $urandom_range(0, 2) != 0) begin
        f_pend = 1'b1; if_addr = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
      end
      if_req = f_pend; d_req = d_pend;
      mem_ack = ($urandom_range(0, 99) < 30);
      mem_rdata = $urandom;
      @(negedge clk);
      e_fin      = (owner != 0) && (mem_ack || el == TO - 1);
      e_abort    = (owner != 0) && !mem_ack && (el == TO - 1);
      e_if_done  = e_fin && owner == 1;
      e_d_done   = e_fin && owner == 2;
      e_if_rdata = (owner == 1 && mem_ack) ? mem_rdata : 32'h0;
      e_d_rdata  = (owner == 2 && mem_ack && !t_we) ? mem_rdata : 32'h0;
      n_checks++;
      if ({if_done, d_done, err_timeout} !== {e_if_done, e_d_done, e_abort}) begin
        n_fail++;
        $display("FAIL rand_done cyc %0d: if_done=%0b d_done=%0b err=%0b, required %0b/%0b/%0b", cyc, if_done, d_done, err_timeout, e_if_done, e_d_done, e_abort);
      end
      n_checks++;
      if ({if_rdata, d_rdata} !== {e_if_rdata, e_d_rdata}) begin
        n_fail++;
        $display("FAIL rand_rdata cyc %0d: if_rdata=%h d_rdata=%h, required %h/%h", cyc, if_rdata, d_rdata, e_if_rdata, e_d_rdata);
      end
      n_checks++;
      if ({stall_if, stall_d, mem_req} !== {if_req & ~e_if_done, d_req & ~e_d_done, owner != 0}) begin
        n_fail++;
        $display("FAIL rand_stall cyc %0d: stall_if=%0b stall_d=%0b mem_req=%0b, required %0b/%0b/%0b", cyc, stall_if, stall_d, mem_req, if_req & ~e_if_done, d_req & ~e_d_done, owner != 0);
      end
      if (owner != 0) begin
        n_checks++;
        if ({mem_addr, mem_we} !== {t_addr, t_we} || (t_we && mem_wdata !== t_wdata)) begin
          n_fail++;
          $display("FAIL rand_mem cyc %0d: addr=%h we=%0b wdata=%h, required %h/%0b/%h", cyc, mem_addr, mem_we, mem_wdata, t_addr, t_we, t_wdata);
        end
      end
      f_fin = e_if_done; d_fin = e_d_done;
      if (e_fin) begin
        owner = 0;
      end else if (owner != 0) begin
        el++;
      end else if (d_req && !(if_req && losses == ST)) begin
        owner = 2; el = 0; t_addr = d_addr; t_we = d_we; t_wdata = d_wdata;
        if (if_req) losses = (losses < ST) ? losses + 1 : ST;
      end else if (if_req) begin
        owner = 1; el = 0; t_addr = if_addr; t_we = 1'b0; losses = 0;
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_reset_mid();
    test_stray_ack();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores) of the 5-stage core.
- Sequences one memory transaction at a time.
- Stalls the losing or waiting stage through stall outputs that feed the hazard unit's StallF and the MEM-stage hold.
- Prioritises data accesses, guards fetch against starvation, and aborts hung transactions on timeout.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_LIMIT, 3, consecutive data grants that fetch may lose before it wins the next tie.
- TIMEOUT, 64, maximum cycles to wait for mem_ack; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- if_req  input  1  fetch read request; held with if_addr until if_done
- if_addr  input  AW  fetch address (pc)
- if_rdata  output  DW  instruction word, valid while if_done=1
- if_done  output  1  fetch transaction complete, single-cycle pulse
- d_req  input  1  data request; held with d_we/d_addr/d_wdata until d_done
- d_we  input  1  1=store, 0=load
- d_addr  input  AW  data address (ALU_Out of the MEM stage)
- d_wdata  input  DW  store data
- d_rdata  output  DW  load data, valid while d_done=1 and the access is a load
- d_done  output  1  data transaction complete, single-cycle pulse
- err_timeout  output  1  pulses together with the done of an aborted transaction
- mem_req  output  1  memory request, held until mem_ack or abort
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address (registered)
- mem_wdata  output  DW  memory write data (registered)
- mem_ack  input  1  memory completion, one cycle; mem_rdata is valid in that cycle
- mem_rdata  input  DW  memory read data
- stall_if  output  1  = if_req & ~if_done
- stall_d  output  1  = d_req & ~d_done

Behaviour:
- Reset is asynchronous and immediate, including mid-transaction. It forces:
  - state=IDLE
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - wait_cnt=0, to_cnt=0
  - owner and op registers cleared
  - all done, err and stall-driving terms 0; rdata outputs 0
- FSM states are IDLE, BUSY_I and BUSY_D.
- IDLE arbitration:
  - d_req only -> BUSY_D.
  - if_req only -> BUSY_I.
  - Both requesting: BUSY_I if wait_cnt==STARVE_LIMIT, otherwise BUSY_D.
  - Neither requesting: stay in IDLE.
- On the grant edge, mem_addr, mem_we and mem_wdata are latched from the winner. Fetch grants use mem_we=0. mem_req=1 from the next cycle on, so grant-to-mem_req latency is 1 cycle.
- wait_cnt:
  - On a grant to data while if_req=1: increments, saturating at STARVE_LIMIT.
  - On any grant to fetch: cleared.
- BUSY_x with mem_ack=1:
  - x_done=1 combinationally in that same cycle.
  - if_rdata=mem_rdata for fetch. d_rdata=mem_rdata for a load, 0 for a store.
  - The next state is IDLE and mem_req is 0 on the following cycle.
  - Other cycles: done=0, rdata=0.
- Back-to-back transactions: the requester drops or changes its request in the cycle after done. IDLE re-arbitrates on the next cycle, so there is at least one idle cycle between memory transactions.
- to_cnt:
  - Cleared on grant; increments on every BUSY cycle without mem_ack.
  - If TIMEOUT!=0 and to_cnt==TIMEOUT-1 with no ack: the owner's done and err_timeout pulse, rdata=0, and the state moves to IDLE.
  - A mem_ack arriving in the same cycle as the timeout wins: normal completion, err_timeout=0.
- mem_ack while IDLE is ignored; a stray ack never produces a done.
- Requests asserted during BUSY are not granted until IDLE. Their stall outputs stay asserted meanwhile.
- Fetch and data addresses are passed through unmodified; no alignment checking.

Decomposition:
- Shared package imem_dmem_arbiter_pkg holds:
  - state enum (IDLE, BUSY_I, BUSY_D)
  - owner enum (OWN_I, OWN_D)
  - default width constants
- One natural sub-module: arb_timeout_counter, a loadable up-counter with compare for to_cnt. The starvation counter stays inline.

Test Plan:
- Fetch-only read: if_req=1, if_addr=0x0000_0010, mem_ack after 2 cycles with mem_rdata=0x0050_0093. Required: mem_req rises 1 cycle after the request, if_done pulses with if_rdata=0x0050_0093, stall_if=1 until the done cycle.
- Simultaneous requests with wait_cnt=0: d_req store, d_addr=0x100, d_wdata=0xDEAD_BEEF. Required: the data grant comes first with mem_we=1, mem_addr=0x100, mem_wdata=0xDEAD_BEEF; d_rdata=0 at d_done; fetch is served next, with stall_if held throughout.
- Starvation: hold if_req and d_req continuously, data re-requesting after each done, STARVE_LIMIT=3. Required: grant order D, D, D, I, D, ..., with wait_cnt saturating at 3 and clearing on the fetch grant.
- Timeout: TIMEOUT=4, d_req load, mem_ack never asserts. Required: d_done=1 and err_timeout=1 on the 4th BUSY cycle, d_rdata=0, mem_req=0 the next cycle. Repeat with mem_ack landing on the 4th cycle: normal completion, err_timeout=0.
- Reset mid-transaction: assert reset asynchronously during BUSY_I. Required: mem_req, if_done and stall_if drop immediately without waiting for clk, and counters read 0 after release.
- Stray ack: pulse mem_ack in IDLE. Required: no done, no state change.
